time_setter: RTL and testbench
==============================

// Module: time_setter
// PURPOSE
//  Operator-side writer for the countdown time register: turns four push-button levels into six BCD
//  digits (HH:MM:SS) plus a one-cycle write strobe. Outputs wire directly to the register's
//  setHour10..setSecond1 and write inputs. Edits are locked out while the countdown runs (busy=1).
// PARAMETERS
//  MAX_HOUR10     2        upper limit of hour tens digit
//  MAX_HOUR1_TOP  3        hour units limit when hour10==MAX_HOUR10 (else 9)
//  REPEAT_CYCLES  500000   clocks a held up/down must persist before auto-repeat; 0 disables repeat
// PORTS
//  clock        in   1  system clock, all state on rising edge
//  reset        in   1  asynchronous, active-low; clears all state
//  btnNext      in   1  level, already debounced; advance cursor
//  btnUp        in   1  level; increment digit at cursor
//  btnDown      in   1  level; decrement digit at cursor
//  btnConfirm   in   1  level; enter edit (IDLE) / commit (EDIT)
//  busy         in   1  countdown running; blocks and aborts editing
//  setHour10..setSecond1  out 4 each  edited BCD digits (registered)
//  write        out  1  one-cycle commit strobe
//  cursor       out  3  0=H10,1=H1,2=M10,3=M1,4=S10,5=S1
//  editing      out  1  high in EDIT
//  reject       out  1  one-cycle pulse: commit refused (all digits zero)
// BEHAVIOUR
//  Reset (reset=0, async): all digits 0, cursor 0, state IDLE, write/reject/editing 0, edge regs 0.
//  Edge detect: each button registered; pulse = level & ~prev. Pulse seen in cycle n -> effect on outputs n+1.
//  States: IDLE, EDIT, COMMIT.
//   IDLE:  confirm pulse && !busy -> EDIT, cursor<=0. Digits hold last committed values. Other buttons ignored.
//   EDIT:  next pulse -> cursor+1, 5 wraps to 0. up/down pulses modify digit at cursor (limits below).
//          confirm pulse: digits all zero -> reject=1 one cycle, stay EDIT; else -> COMMIT.
//          busy=1 -> IDLE immediately (abort, digits keep edited values, no write).
//   COMMIT: write=1 for exactly this cycle, digits stable, -> IDLE next cycle.
//  Digit limits: H10 0..MAX_HOUR10; H1 0..9 (0..MAX_HOUR1_TOP if H10==MAX_HOUR10); M10,S10 0..5; M1,S1 0..9.
//   up at max -> 0; down at 0 -> max. Raising H10 to MAX_HOUR10 with H1>MAX_HOUR1_TOP clamps H1 to MAX_HOUR1_TOP
//   in the same cycle.
//  Simultaneous: up&down same cycle -> no change; up/down with next same cycle -> modify current digit,
//   then advance cursor; confirm with any other pulse -> confirm wins, others dropped.
//  Auto-repeat (REPEAT_CYCLES>0): counter runs while exactly one of up/down held in EDIT; reaching
//   REPEAT_CYCLES-1 issues one repeat step and reloads 0; release, cursor move or state exit clears counter.
//  Counter width $clog2(REPEAT_CYCLES+1); digits never leave BCD range in any path.
// TESTING
//  1 reset low mid-EDIT with digits 12:34:56 -> next cycle all outputs 0, editing=0, cursor=0.
//  2 IDLE, confirm; up x1 on H10, next, up x5 on H1 -> H10=1,H1=5; confirm -> write one cycle then editing=0.
//  3 H10=1,H1=7, cursor0, up -> H10=2,H1=3 same cycle; up again -> H10=0; down at M10=0 -> 5.
//  4 all zero, confirm in EDIT -> reject=1 one cycle, write=0, editing stays 1.
//  5 busy=1 in EDIT -> editing=0 next cycle, write never asserted; confirm while busy in IDLE -> stays IDLE.
//  6 REPEAT_CYCLES=4, hold up on S1 for 13 cycles from 0 -> S1=1 from edge then +1 every 4 cycles -> S1=4.

Source files
------------

// File: rtl/time_setter_if.sv
`default_nettype none
// ============================================================================
// Module      : time_setter_if
// Description : Button inputs and BCD digit / strobe outputs of time_setter.
// Revision    : 1.0 - initial release
// ============================================================================
interface time_setter_if;
    logic       btnNext;
    logic       btnUp;
    logic       btnDown;
    logic       btnConfirm;
    logic       busy;
    logic [3:0] setHour10;
    logic [3:0] setHour1;
    logic [3:0] setMinute10;
    logic [3:0] setMinute1;
    logic [3:0] setSecond10;
    logic [3:0] setSecond1;
    logic       write;
    logic [2:0] cursor;
    logic       editing;
    logic       reject;

    modport master (
        output btnNext, btnUp, btnDown, btnConfirm, busy,
        input  setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1,
        input  write, cursor, editing, reject
    );

    modport slave (
        input  btnNext, btnUp, btnDown, btnConfirm, busy,
        output setHour10, setHour1, setMinute10, setMinute1, setSecond10, setSecond1,
        output write, cursor, editing, reject
    );
endinterface
`default_nettype wire

// File: rtl/time_setter.sv
`default_nettype none
// ============================================================================
// Module      : time_setter
// Description : Push-button editor producing six BCD digits (HH:MM:SS) and a
//               one-cycle write strobe for the countdown time register.
// Revision    : 1.0 - initial release
// ============================================================================
module time_setter #(
    parameter int MAX_HOUR10    = 2,
    parameter int MAX_HOUR1_TOP = 3,
    parameter int REPEAT_CYCLES = 500000
) (
    input  wire logic     clock,
    input  wire logic     reset,
    time_setter_if.slave  bus
);

    localparam int             c_cnt_w    = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = (REPEAT_CYCLES > 0) ? c_cnt_w'(REPEAT_CYCLES - 1) : '0;
    localparam logic [3:0]     c_h10_max  = 4'(MAX_HOUR10);
    localparam logic [3:0]     c_h1_top   = 4'(MAX_HOUR1_TOP);
    localparam logic           c_rep_en   = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [5:0][3:0]    r_dig;          // [0]=H10 ... [5]=S1
    logic [2:0]         r_cursor;
    logic               r_write;
    logic               r_reject;
    logic               r_editing;
    logic               r_prev_next;
    logic               r_prev_up;
    logic               r_prev_down;
    logic               r_prev_conf;
    logic [c_cnt_w-1:0] r_rep_cnt;

    logic               w_next_p;
    logic               w_up_p;
    logic               w_dn_p;
    logic               w_conf_p;
    logic               w_hold_one;
    logic               w_rep_fire;
    logic               w_inc;
    logic               w_dec;
    logic [3:0]         w_cur;
    logic [3:0]         w_max;
    logic [3:0]         w_new;
    logic [5:0][3:0]    w_dig;
    logic [2:0]         w_cursor_nx;
    logic               w_all_zero;

    assign w_next_p   = bus.btnNext    & ~r_prev_next;
    assign w_up_p     = bus.btnUp      & ~r_prev_up;
    assign w_dn_p     = bus.btnDown    & ~r_prev_down;
    assign w_conf_p   = bus.btnConfirm & ~r_prev_conf;
    assign w_hold_one = bus.btnUp ^ bus.btnDown;

    // A repeat step only comes from a steady hold; the pressing edge itself steps via the pulse.
    assign w_rep_fire = c_rep_en && w_hold_one && !w_up_p && !w_dn_p && (r_rep_cnt == c_cnt_last);
    assign w_inc      = (w_up_p & ~w_dn_p) | (w_rep_fire & bus.btnUp);
    assign w_dec      = (w_dn_p & ~w_up_p) | (w_rep_fire & bus.btnDown);

    assign w_cursor_nx = (r_cursor >= 3'd5) ? 3'd0 : r_cursor + 3'd1;
    assign w_all_zero  = (r_dig == '0);

    always_comb begin
        w_cur = 4'd0;
        w_max = 4'd9;
        case (r_cursor)
            3'd0: begin w_cur = r_dig[0]; w_max = c_h10_max; end
            3'd1: begin w_cur = r_dig[1]; w_max = (r_dig[0] == c_h10_max) ? c_h1_top : 4'd9; end
            3'd2: begin w_cur = r_dig[2]; w_max = 4'd5; end
            3'd3: begin w_cur = r_dig[3]; w_max = 4'd9; end
            3'd4: begin w_cur = r_dig[4]; w_max = 4'd5; end
            3'd5: begin w_cur = r_dig[5]; w_max = 4'd9; end
            default: begin w_cur = 4'd0; w_max = 4'd9; end
        endcase
    end

    always_comb begin
        w_new = w_cur;
        if (w_inc) begin
            w_new = (w_cur >= w_max) ? 4'd0 : w_cur + 4'd1;
        end else if (w_dec) begin
            w_new = ((w_cur == 4'd0) || (w_cur > w_max)) ? w_max : w_cur - 4'd1;
        end
    end

    always_comb begin
        w_dig = r_dig;
        case (r_cursor)
            3'd0:    w_dig[0] = w_new;
            3'd1:    w_dig[1] = w_new;
            3'd2:    w_dig[2] = w_new;
            3'd3:    w_dig[3] = w_new;
            3'd4:    w_dig[4] = w_new;
            3'd5:    w_dig[5] = w_new;
            default: w_dig    = r_dig;
        endcase
        // Reaching the top hour decade shrinks the hour-units range immediately.
        if ((w_dig[0] == c_h10_max) && (w_dig[1] > c_h1_top)) begin
            w_dig[1] = c_h1_top;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_dig       <= '0;
            r_cursor    <= 3'd0;
            r_write     <= 1'b0;
            r_reject    <= 1'b0;
            r_editing   <= 1'b0;
            r_prev_next <= 1'b0;
            r_prev_up   <= 1'b0;
            r_prev_down <= 1'b0;
            r_prev_conf <= 1'b0;
            r_rep_cnt   <= '0;
        end else begin
            r_prev_next <= bus.btnNext;
            r_prev_up   <= bus.btnUp;
            r_prev_down <= bus.btnDown;
            r_prev_conf <= bus.btnConfirm;
            r_write     <= 1'b0;
            r_reject    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_rep_cnt <= '0;
                    if (w_conf_p && !bus.busy) begin
                        r_state   <= S_EDIT;
                        r_cursor  <= 3'd0;
                        r_editing <= 1'b1;
                    end
                end

                S_EDIT: begin
                    if (bus.busy) begin
                        r_state   <= S_IDLE;
                        r_editing <= 1'b0;
                        r_rep_cnt <= '0;
                    end else if (w_conf_p) begin
                        r_rep_cnt <= '0;
                        if (w_all_zero) begin
                            r_reject <= 1'b1;
                        end else begin
                            r_state   <= S_COMMIT;
                            r_write   <= 1'b1;
                            r_editing <= 1'b0;
                        end
                    end else begin
                        r_dig <= w_dig;
                        if (w_next_p) begin
                            r_cursor  <= w_cursor_nx;
                            r_rep_cnt <= '0;
                        end else if (!c_rep_en || !w_hold_one || w_up_p || w_dn_p || w_rep_fire) begin
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_cnt_w'(1);
                        end
                    end
                end

                S_COMMIT: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_editing <= 1'b0;
                    r_rep_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.setHour10   = r_dig[0];
    assign bus.setHour1    = r_dig[1];
    assign bus.setMinute10 = r_dig[2];
    assign bus.setMinute1  = r_dig[3];
    assign bus.setSecond10 = r_dig[4];
    assign bus.setSecond1  = r_dig[5];
    assign bus.write       = r_write;
    assign bus.cursor      = r_cursor;
    assign bus.editing     = r_editing;
    assign bus.reject      = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_time_setter.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_setter
// Description : Directed self-checking bench for time_setter (REPEAT_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_setter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   wr_seen;
    int   rj_seen;
    int   wr_before;

    time_setter_if bus ();

    time_setter #(
        .MAX_HOUR10    (2),
        .MAX_HOUR1_TOP (3),
        .REPEAT_CYCLES (4)
    ) u_dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.write)  wr_seen <= wr_seen + 1;
        if (bus.reject) rj_seen <= rj_seen + 1;
    end

    function automatic logic [23:0] digits();
        return {bus.setHour10, bus.setHour1, bus.setMinute10,
                bus.setMinute1, bus.setSecond10, bus.setSecond1};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // m = {confirm, down, up, next}; held for exactly one rising edge
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        bus.btnNext    = m[0];
        bus.btnUp      = m[1];
        bus.btnDown    = m[2];
        bus.btnConfirm = m[3];
        @(negedge clk);
        bus.btnNext    = 1'b0;
        bus.btnUp      = 1'b0;
        bus.btnDown    = 1'b0;
        bus.btnConfirm = 1'b0;
    endtask

    localparam logic [3:0] c_next = 4'b0001;
    localparam logic [3:0] c_up   = 4'b0010;
    localparam logic [3:0] c_down = 4'b0100;
    localparam logic [3:0] c_conf = 4'b1000;

    initial begin
        n_total = 0;
        n_bad   = 0;
        wr_seen = 0;
        rj_seen = 0;
        rst_n   = 1'b0;
        bus.btnNext = 1'b0; bus.btnUp = 1'b0; bus.btnDown = 1'b0;
        bus.btnConfirm = 1'b0; bus.busy = 1'b0;

        #12;
        check_value("rst_digits",  32'(digits()),    32'h000000);
        check_value("rst_cursor",  32'(bus.cursor),  32'd0);
        check_value("rst_editing", 32'(bus.editing), 32'd0);
        check_value("rst_write",   32'(bus.write),   32'd0);
        check_value("rst_reject",  32'(bus.reject),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // all-zero commit is refused
        press(c_conf);
        check_value("enter_edit",   32'(bus.editing), 32'd1);
        check_value("enter_cursor", 32'(bus.cursor),  32'd0);
        press(c_conf);
        check_value("rej_pulse",    32'(bus.reject),  32'd1);
        check_value("rej_nowrite",  32'(bus.write),   32'd0);
        check_value("rej_editing",  32'(bus.editing), 32'd1);
        @(negedge clk);
        check_value("rej_oneshot",  32'(bus.reject),  32'd0);

        // basic edit and commit
        press(c_up);
        check_value("h10_up",      32'(digits()),   32'h100000);
        press(c_next);
        check_value("cursor_1",    32'(bus.cursor), 32'd1);
        repeat (5) press(c_up);
        check_value("h1_up5",      32'(digits()),   32'h150000);
        press(c_conf);
        check_value("commit_wr",   32'(bus.write),  32'd1);
        @(negedge clk);
        check_value("commit_wr_off", 32'(bus.write),   32'd0);
        check_value("commit_idle",   32'(bus.editing), 32'd0);
        check_value("commit_hold",   32'(digits()),    32'h150000);

        // hour clamp, wraps, simultaneous buttons
        press(c_conf);
        press(c_next);
        press(c_up);
        press(c_up);
        check_value("h1_to7",      32'(digits()),   32'h170000);
        repeat (5) press(c_next);
        check_value("cursor_wrap", 32'(bus.cursor), 32'd0);
        press(c_up);
        check_value("h10_clamp",   32'(digits()),   32'h230000);
        press(c_up);
        check_value("h10_wrap",    32'(digits()),   32'h030000);
        press(c_next);
        press(c_next);
        press(c_down);
        check_value("m10_down0",   32'(digits()),   32'h035000);
        press(c_up | c_down);
        check_value("updown_same", 32'(digits()),   32'h035000);
        press(c_up | c_next);
        check_value("upnext_dig",  32'(digits()),   32'h030000);
        check_value("upnext_cur",  32'(bus.cursor), 32'd3);

        // auto-repeat on S1
        press(c_next);
        press(c_next);
        check_value("cursor_5",    32'(bus.cursor), 32'd5);
        @(negedge clk);
        bus.btnUp = 1'b1;
        @(negedge clk);
        check_value("rep_first",   32'(digits()),   32'h030001);
        repeat (12) @(negedge clk);
        bus.btnUp = 1'b0;
        check_value("rep_13cyc",   32'(digits()),   32'h030004);
        @(negedge clk);
        check_value("rep_release", 32'(digits()),   32'h030004);
        press(c_conf);
        check_value("commit2_wr",  32'(bus.write),  32'd1);
        check_value("commit2_dig", 32'(digits()),   32'h030004);
        @(negedge clk);
        check_value("wr_count",    32'(wr_seen),    32'd2);
        check_value("rj_count",    32'(rj_seen),    32'd1);

        // busy aborts editing and blocks entry
        wr_before = wr_seen;
        press(c_conf);
        check_value("busy_pre_edit", 32'(bus.editing), 32'd1);
        bus.busy = 1'b1;
        @(negedge clk);
        check_value("busy_abort",    32'(bus.editing), 32'd0);
        press(c_conf);
        check_value("busy_block",    32'(bus.editing), 32'd0);
        repeat (2) @(negedge clk);
        check_value("busy_nowrite",  32'(wr_seen),     32'(wr_before));
        bus.busy = 1'b0;

        // build 12:34:56 then reset mid-edit
        press(c_conf);
        press(c_up);
        press(c_next);
        press(c_down);
        press(c_next);
        repeat (3) press(c_up);
        press(c_next);
        repeat (4) press(c_up);
        press(c_next);
        repeat (5) press(c_up);
        press(c_next);
        repeat (2) press(c_up);
        check_value("edit_123456", 32'(digits()),    32'h123456);
        check_value("edit_cur5",   32'(bus.cursor),  32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("arst_digits",  32'(digits()),    32'h000000);
        check_value("arst_editing", 32'(bus.editing), 32'd0);
        check_value("arst_cursor",  32'(bus.cursor),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("post_rst_dig", 32'(digits()),    32'h000000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
